rr_arbiter8: RTL and testbench

- Eight-requester round-robin arbiter that shares one downstream resource among requesters.
- Built around an 8-to-3 priority encoding, wrapped with a rotating priority pointer, grant hold, and a hold-time limit.
- Sits between request sources and the shared resource.
- Registered outputs: one-hot grant, binary grant index, grant valid, and a timeout pulse.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_priority_pick.sv | 33 +++
 rtl/rr_arbiter8.sv | 126 ++++++++++++
 tb/tb_rr_arbiter8.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and index helpers for the round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Binary requester index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority search: first set bit of (req & mask) at or after ptr,
// ascending and wrapping from the top index back to 0.
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] masked;

  assign masked = req & mask;

  // Walk the eight positions starting at ptr; the earliest hit wins.
  always_comb begin
    logic [IDX_W-1:0] k;
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the logic leaves it unassigned and a latch is never inferred.
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = ptr + IDX_W'(i);
      if (!found && masked[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with grant hold and a hold-time limit.
// The owner keeps the grant until it drops its request; if others are waiting
// it is revoked after MAX_HOLD cycles and timeout pulses for one cycle.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] gnt_idx_d;
  logic             gnt_valid_d;
  logic             timeout_d;

  logic [IDX_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_mask;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] owner_next;

  // gnt_idx holds the current owner whenever a grant is held.
  assign owner_next = gnt_idx + IDX_W'(1);

  rr_priority_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state, pointer, hold counter and next output values.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_idx_d   = gnt_idx;
    gnt_valid_d = gnt_valid;
    timeout_d   = 1'b0;
    pick_ptr    = ptr_q;
    pick_mask   = '1;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end else begin
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end
      end

      GRANT: begin
        // Both release and revocation search just past the owner, owner excluded.
        pick_ptr  = owner_next;
        pick_mask = ~idx_to_onehot(gnt_idx);
        if (!req[gnt_idx]) begin
          // Release wins over the limit when both happen together.
          ptr_d      = owner_next;
          hold_cnt_d = '0;
          if (pick_found) begin
            gnt_idx_d = pick_idx;
          end else begin
            state_d     = IDLE;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
          end
        end else if (hold_cnt_q < HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
          hold_cnt_d = '0;
          if (pick_found) begin
            ptr_d     = owner_next;
            gnt_idx_d = pick_idx;
            timeout_d = 1'b1;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt        <= '0;
      gnt_idx    <= '0;
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt        <= gnt_valid_d ? idx_to_onehot(gnt_idx_d) : '0;
      gnt_idx    <= gnt_idx_d;
      gnt_valid  <= gnt_valid_d;
      timeout    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: each cycle's stimulus is paired with the
// outputs expected after the edge that samples it; expectations go through a
// queue and are compared one time unit after that edge.
module tb_rr_arbiter8;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       v;
    logic [2:0] idx;
    logic       to;
  } vec_t;

  typedef struct {
    int         n;
    logic       v;
    logic [2:0] idx;
    logic       to;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   n_drv = 0;

  rr_arbiter8 #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue its expectation.
  task automatic apply(input logic rst, input logic [7:0] r, input logic v,
                       input logic [2:0] idx, input logic to);
    exp_t e;
    @(negedge clk);
    reset = rst;
    req   = r;
    e.n   = n_drv;
    e.v   = v;
    e.idx = idx;
    e.to  = to;
    sb.push_back(e);
    n_drv++;
  endtask

  // Scoreboard consumer: compare outputs just after each rising edge.
  initial begin
    exp_t       e;
    logic [7:0] exp_gnt;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e       = sb.pop_front();
        exp_gnt = e.v ? (8'h01 << e.idx) : 8'h00;
        check($sformatf("c%0d gnt", e.n),       32'(gnt),       32'(exp_gnt));
        check($sformatf("c%0d gnt_idx", e.n),   32'(gnt_idx),   32'(e.v ? e.idx : 3'd0));
        check($sformatf("c%0d gnt_valid", e.n), 32'(gnt_valid), 32'(e.v));
        check($sformatf("c%0d timeout", e.n),   32'(timeout),   32'(e.to));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req   = 8'h00;

    // Reset, first grant, back-to-back release, rotation between 0 and 1.
    vecs.push_back('{1'b1, 8'b0000_0000, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{1'b1, 8'b0000_0000, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'b1001_0000, 1'b1, 3'd4, 1'b0});
    vecs.push_back('{1'b0, 8'b1001_0000, 1'b1, 3'd4, 1'b0});
    vecs.push_back('{1'b0, 8'b1000_0000, 1'b1, 3'd7, 1'b0});
    vecs.push_back('{1'b0, 8'b0000_0000, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'b0000_0000, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'b0000_0011, 1'b1, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'b0000_0011, 1'b1, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'b0000_0010, 1'b1, 3'd1, 1'b0});
    vecs.push_back('{1'b0, 8'b0000_0011, 1'b1, 3'd1, 1'b0});
    vecs.push_back('{1'b0, 8'b0000_0011, 1'b1, 3'd1, 1'b0});
    vecs.push_back('{1'b0, 8'b0000_0001, 1'b1, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'b0000_0011, 1'b1, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'b0000_0011, 1'b1, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'b0000_0010, 1'b1, 3'd1, 1'b0});
    vecs.push_back('{1'b0, 8'b0000_0011, 1'b1, 3'd1, 1'b0});
    vecs.push_back('{1'b0, 8'b0000_0000, 1'b0, 3'd0, 1'b0});
    // ptr is now 2: search 2..7 finds nothing, wraps to 0.
    vecs.push_back('{1'b0, 8'b0000_0011, 1'b1, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'b0000_0000, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{1'b1, 8'b0000_0000, 1'b0, 3'd0, 1'b0});

    foreach (vecs[i])
      apply(vecs[i].rst, vecs[i].req, vecs[i].v, vecs[i].idx, vecs[i].to);

    // Hold limit: owner 0 for 16 cycles, revoked to 6 with a timeout pulse,
    // then 6 for 16 cycles and revoked back to 0 (search wraps from 7).
    for (int i = 0; i < 16; i++) apply(1'b0, 8'b0100_0001, 1'b1, 3'd0, 1'b0);
    apply(1'b0, 8'b0100_0001, 1'b1, 3'd6, 1'b1);
    for (int i = 0; i < 15; i++) apply(1'b0, 8'b0100_0001, 1'b1, 3'd6, 1'b0);
    apply(1'b0, 8'b0100_0001, 1'b1, 3'd0, 1'b1);
    apply(1'b0, 8'b0100_0001, 1'b1, 3'd0, 1'b0);
    apply(1'b0, 8'b0000_0000, 1'b0, 3'd0, 1'b0);   // release of 0, ptr -> 1

    // Sole requester: grant kept across limit boundaries, no timeout.
    for (int i = 0; i < 40; i++) apply(1'b0, 8'b0000_1000, 1'b1, 3'd3, 1'b0);
    apply(1'b0, 8'b0000_0000, 1'b0, 3'd0, 1'b0);   // release of 3, ptr -> 4

    // Reset mid-grant, then search restarts from ptr 0.
    apply(1'b0, 8'b1111_1111, 1'b1, 3'd4, 1'b0);
    apply(1'b0, 8'b1111_1111, 1'b1, 3'd4, 1'b0);
    apply(1'b1, 8'b1111_1111, 1'b0, 3'd0, 1'b0);
    apply(1'b0, 8'b1111_1111, 1'b1, 3'd0, 1'b0);

    // Release coinciding with the limit cycle: release wins, no timeout.
    for (int i = 0; i < 15; i++) apply(1'b0, 8'b1111_1111, 1'b1, 3'd0, 1'b0);
    apply(1'b0, 8'b1111_1110, 1'b1, 3'd1, 1'b0);
    apply(1'b1, 8'b0000_0000, 1'b0, 3'd0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
